// File: rtl/shift_result_stage.sv
// Registered output stage after the barrel shifter: derives Z/N/C flags at
// acceptance and buffers result+flags in a two-entry skid buffer so that
// in_ready never depends combinationally on out_ready.
module shift_result_stage #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEVEL = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_y,
   input  logic [WIDTH-1:0] in_a,
   input  logic [LEVEL-1:0] in_b,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_z,
   output logic             out_n,
   output logic             out_c
);

   localparam logic [1:0] OP_SRL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   // Result plus its condition flags, stored together per slot
   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic             z;
      logic             n;
      logic             c;
   } entry_t;

   // Encoding is {out_valid, skid_valid}
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_e;

   state_e           state_q, state_d;
   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   logic             in_ready_q, in_ready_d;

   entry_t           new_e;
   logic             carry;
   logic [LEVEL-1:0] srl_idx;
   logic [LEVEL-1:0] sll_idx;
   logic             acc;
   logic             rel;

   // Index arithmetic wraps at LEVEL bits; WIDTH - b is only used when b != 0
   assign srl_idx = in_b - LEVEL'(1);
   assign sll_idx = LEVEL'(WIDTH) - in_b;

   // Carry: last bit shifted out for logical shifts, wrapped bit for rotates
   always_comb begin
      carry = 1'b0;
      if (in_b != '0) begin
         case (in_op)
            OP_SRL:  carry = in_a[srl_idx];
            OP_SLL:  carry = in_a[sll_idx];
            OP_ROR:  carry = in_y[WIDTH-1];
            OP_ROL:  carry = in_y[0];
            default: carry = 1'b0;
         endcase
      end
   end

   assign new_e.y = in_y;
   assign new_e.z = (in_y == '0);
   assign new_e.n = in_y[WIDTH-1];
   assign new_e.c = carry;

   assign acc = in_valid && in_ready_q;
   assign rel = state_q[1] && out_ready;

   // Next-state and slot updates for the skid buffer
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (acc) begin
               main_d  = new_e;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (acc && rel) begin
               main_d = new_e;
            end else if (acc) begin
               skid_d  = new_e;
               state_d = ST_FULL;
            end else if (rel) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (rel) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d = (state_d != ST_FULL);
   end

   // State and storage registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = state_q[1];
   assign out_y     = main_q.y;
   assign out_z     = main_q.z;
   assign out_n     = main_q.n;
   assign out_c     = main_q.c;

endmodule

// File: tb/tb_shift_result_stage.sv
// Bench for shift_result_stage: directed cases plus randomized traffic
// checked every cycle against a queue-based model of the stage.
module tb_shift_result_stage;

   localparam int unsigned W = 8;
   localparam int unsigned L = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_y;
   logic [W-1:0] in_a;
   logic [L-1:0] in_b;
   logic [1:0]   in_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_y;
   logic         out_z;
   logic         out_n;
   logic         out_c;

   int total = 0;
   int bad   = 0;

   shift_result_stage #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_y(in_y), .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_z(out_z), .out_n(out_n), .out_c(out_c)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] y;
      logic         z;
      logic         n;
      logic         c;
   } ent_t;

   // Model state: a FIFO of at most two entries
   ent_t q[$];
   bit   rdy_m   = 1'b0;
   bit   acc_m   = 1'b0;
   bit   clean_m = 1'b1;
   bit   started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [W-1:0] shf(input logic [W-1:0] a, input logic [L-1:0] b,
                                        input logic [1:0] op);
      int ai = int'(a);
      int bi = int'(b);
      int r;
      case (op)
         2'd0:    r = ai >> bi;
         2'd1:    r = ai << bi;
         2'd2:    r = (ai >> bi) | (ai << (W - bi));
         default: r = (ai << bi) | (ai >> (W - bi));
      endcase
      return W'(r);
   endfunction

   function automatic ent_t mk(input logic [W-1:0] a, input logic [L-1:0] b,
                               input logic [1:0] op, input logic [W-1:0] y);
      ent_t e;
      int ai = int'(a);
      int bi = int'(b);
      e.y = y;
      e.z = (y == 0);
      e.n = y[W-1];
      if (bi == 0) e.c = 1'b0;
      else begin
         case (op)
            2'd0:    e.c = 1'((ai >> (bi - 1)) & 1);
            2'd1:    e.c = 1'((ai >> (W - bi)) & 1);
            2'd2:    e.c = y[W-1];
            default: e.c = y[0];
         endcase
      end
      return e;
   endfunction

   // Model update at the active edge
   always @(posedge clk) begin
      bit rel;
      if (!rst_n) begin
         q.delete();
         rdy_m   = 1'b0;
         acc_m   = 1'b0;
         clean_m = 1'b1;
      end else begin
         acc_m = in_valid && rdy_m;
         rel   = (q.size() > 0) && out_ready;
         if (rel) void'(q.pop_front());
         if (acc_m) begin
            q.push_back(mk(in_a, in_b, in_op, in_y));
            clean_m = 1'b0;
         end
         rdy_m = (q.size() < 2);
      end
      started = 1'b1;
   end

   // Compare DUT outputs to the model away from the active edge
   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", 32'(in_ready), 32'(rdy_m));
         chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
         if (q.size() > 0) begin
            chk("out_y", 32'(out_y), 32'(q[0].y));
            chk("flags", 32'({out_z, out_n, out_c}), 32'({q[0].z, q[0].n, q[0].c}));
         end else if (clean_m) begin
            chk("rst_y", 32'(out_y), 32'd0);
            chk("rst_flags", 32'({out_z, out_n, out_c}), 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic put(input logic [1:0] op, input logic [W-1:0] a, input logic [L-1:0] b,
                      input logic [W-1:0] y);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_y     = y;
   endtask

   task automatic put_rand();
      logic [W-1:0] a;
      logic [L-1:0] b;
      logic [1:0]   op;
      a  = W'($urandom);
      b  = L'($urandom);
      op = 2'($urandom);
      put(op, a, b, shf(a, b, op));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_y = '0; in_a = '0; in_b = '0; in_op = '0;

      // Reset state
      step(); step();
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_ready", 32'(in_ready), 32'd0);
      chk("reset_y", 32'(out_y), 32'd0);
      rst_n = 1'b1;
      step();
      chk("post_reset_ready", 32'(in_ready), 32'd1);

      // Directed flag cases, one per cycle
      out_ready = 1'b1;
      put(2'd0, 8'h81, 3'd1, 8'h40); step();
      chk("srl_y", 32'(out_y), 32'h40);
      chk("srl_zncc", 32'({out_z, out_n, out_c}), 32'b001);
      put(2'd1, 8'h81, 3'd1, 8'h02); step();
      chk("sll_zncc", 32'({out_z, out_n, out_c}), 32'b001);
      put(2'd2, 8'h01, 3'd1, 8'h80); step();
      chk("ror_zncc", 32'({out_z, out_n, out_c}), 32'b011);
      put(2'd0, 8'h00, 3'd0, 8'h00); step();
      chk("srl0_zncc", 32'({out_z, out_n, out_c}), 32'b100);
      put(2'd3, 8'h80, 3'd0, 8'h80); step();
      chk("rol0_zncc", 32'({out_z, out_n, out_c}), 32'b010);
      chk("rol0_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      step();

      // Backpressure: third entry held upstream while full
      out_ready = 1'b0;
      put(2'd0, 8'h11, 3'd0, 8'h11); step();
      put(2'd0, 8'h22, 3'd0, 8'h22); step();
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      put(2'd0, 8'h33, 3'd0, 8'h33); step();
      chk("bp_main", 32'(out_y), 32'h11);
      chk("bp_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      chk("bp_second", 32'(out_y), 32'h22);
      step();
      chk("bp_third", 32'(out_y), 32'h33);
      chk("bp_third_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      step();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Streaming: one transfer per cycle, in_ready never drops
      for (int i = 0; i < 8; i++) begin
         put_rand();
         step();
         chk("stream_ready", 32'(in_ready), 32'd1);
         chk("stream_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      step();

      // Reset while full discards both entries
      out_ready = 1'b0;
      put(2'd0, 8'h5A, 3'd0, 8'h5A); step();
      put(2'd0, 8'hA5, 3'd0, 8'hA5); step();
      chk("full_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      step();
      chk("afterrst_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step();
      chk("afterrst_valid", 32'(out_valid), 32'd0);

      // Random traffic, holding each offer until accepted
      for (int i = 0; i < 3000; i++) begin
         if (!in_valid || acc_m) begin
            if ($urandom_range(0, 3) != 0) put_rand();
            else in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 9) < 7);
         rst_n     = ($urandom_range(0, 255) != 0);
         step();
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
